fb_vga_reader: RTL and testbench
================================

FB_VGA_READER -- requirements
Module: fb_vga_reader

Interface
REQ-001 Parameter LINE_WORDS, default 80: SPRAM words per stored image line (160 px, 2 px per word).
REQ-002 Parameter IMG_ROWS, default 120: stored image lines; each line is shown as 4 display rows.
REQ-003 Parameter BLANK_RGB, default 6'b000000: colour driven outside the active area.
REQ-004 clk_25MHz  input  1  sole clock; every register is updated on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk_25MHz.
REQ-006 valid  input  1  VGA timing active-area flag, aligned with row/col.
REQ-007 row  input  10  VGA display row, 0..479 when valid.
REQ-008 col  input  10  VGA display column, 0..639 when valid.
REQ-009 hsync_in  input  1  raw HSYNC from the VGA timing generator.
REQ-010 vsync_in  input  1  raw VSYNC from the VGA timing generator.
REQ-011 test_mode  input  1  1 = drive the internal colour-bar pattern instead of SPRAM data.
REQ-012 spram_do  input  16  SPRAM read data; pixel A in [5:0], pixel B in [13:8], other bits ignored.
REQ-013 spram_ad  output  14  SPRAM word address; the SPRAM runs with WE=0 and CS=1 and this block never writes it.
REQ-014 RGB  output  6  pixel colour {R[1:0],G[1:0],B[1:0]}.
REQ-015 VGA_HSYNC  output  1  hsync_in delayed to match the RGB latency.
REQ-016 VGA_VSYNC  output  1  vsync_in delayed to match the RGB latency.
REQ-017 frame_start  output  1  one-cycle pulse, aligned with RGB, on the first active pixel (row 0, col 0).

Function
REQ-018 Stage 1 (S1) shall register spram_ad = (row>>2)*LINE_WORDS + (col>>3), computed as shifts and adds with no multiplier.
- For the default: (row[9:2]<<6) + (row[9:2]<<4) + col[9:3].
REQ-019 S1 shall register valid, col[2], test_mode, hsync_in and vsync_in, and the first-pixel flag (valid && row==0 && col==0), alongside spram_ad.
REQ-020 Stage 2 (S2) shall correspond to the SPRAM read cycle, with spram_do valid one cycle after spram_ad.
- S2 shall forward all S1 side-band bits unchanged.
REQ-021 Stage 3 (S3) shall register RGB, VGA_HSYNC, VGA_VSYNC and frame_start.
REQ-022 The fixed latency from row/col/valid/sync input to the matching RGB/sync/frame_start output shall be exactly 3 cycles.
REQ-023 S3 pixel select shall be: col[2]==0 -> spram_do[5:0], col[2]==1 -> spram_do[13:8], so each pixel spans 4 display columns and each word spans 8.
REQ-024 When the delayed valid is 0, RGB shall be BLANK_RGB, regardless of test_mode or spram_do.
REQ-025 When the delayed valid is 1 and the delayed test_mode is 1, RGB shall be {col[9:7] mod 4 replicated as bars}, defined as RGB = {3{col[8:7]}} using the delayed col[8:7].
- col[8:7] shall be carried through S1/S2 for this purpose.
REQ-026 If (row>>2) >= IMG_ROWS while valid, the address shall saturate at IMG_ROWS*LINE_WORDS-1 and RGB shall be BLANK_RGB.
REQ-027 spram_ad shall hold its last value while valid is 0; it shall not toggle during blanking.
REQ-028 A test_mode change mid-frame shall take effect on the pixel whose inputs were sampled with the new value, 3 cycles later, with no glitch pixel.
REQ-029 An address wrap from the last word of a line (79) to the first word of the next stored line (80) shall occur at display row multiples of 4 only; rows 4k..4k+3 shall read identical addresses.

Reset
REQ-030 While rst_n=0 at a clock edge, all pipeline registers shall clear: spram_ad=0, RGB=BLANK_RGB, VGA_HSYNC=1, VGA_VSYNC=1, frame_start=0, delayed valid=0.
REQ-031 Reset asserted mid-line shall blank the output on the next edge.
- Normal output shall resume 3 cycles after rst_n returns to 1, with no stale pixel emitted.

Verification
REQ-032 Inputs row=5, col=13, valid=1 -> spram_ad=(1*80+1)=81 one cycle later; with spram_do=16'h2A15, RGB=6'h2A three cycles after input (col[2]=1).
REQ-033 Inputs row=0, col=0, valid=1 -> frame_start=1 for exactly one cycle at cycle+3; spram_ad=0; RGB=spram_do[5:0].
REQ-034 hsync_in pulse 96 cycles wide -> VGA_HSYNC pulse of identical width, delayed exactly 3 cycles; RGB=BLANK_RGB throughout while valid=0.
REQ-035 test_mode=1, col=384 (col[8:7]=2'b11), valid=1 -> RGB=6'b111111 at cycle+3, independent of spram_do.
REQ-036 Drive one full frame with spram_do echoing spram_ad -> spram_ad sequence is monotonic within each row, repeats 4 times per stored line, maximum value 9599, and holds during blanking.
REQ-037 Pull rst_n low for 1 cycle mid-line -> next-edge RGB=BLANK_RGB, VGA_HSYNC=1, frame_start=0; correct pixels resume exactly 3 cycles after release.

Source files
------------

// File: rtl/fb_vga_reader.sv
// -----------------------------------------------------------------------------
// fb_vga_reader
//
// Purpose:
//   Three-stage read pipeline that turns VGA scan coordinates into pixels
//   fetched from a single-port RAM frame buffer. The stored image is
//   160x120 pixels at 6 bits each, packed 2 pixels per 16-bit word. Each
//   stored pixel is shown as a 4x4 block on the 640x480 display.
//
//   Stage 1 registers the word address and the side-band bits.
//   Stage 2 is the RAM read cycle; it forwards the side-band bits.
//   Stage 3 picks the pixel (or test bar, or blank) and registers the
//   outputs. Input to output latency is exactly 3 clocks for every signal.
//
// Ports:
//   clk_25MHz    in   pixel clock, all registers use its rising edge
//   rst_n        in   synchronous active-low reset
//   valid        in   active-area flag, aligned with row/col
//   row, col     in   display coordinates (10 bits each)
//   hsync_in     in   raw HSYNC from the timing generator
//   vsync_in     in   raw VSYNC from the timing generator
//   test_mode    in   1 = show colour bars instead of RAM data
//   spram_do     in   RAM read data, pixel A [5:0], pixel B [13:8]
//   spram_ad     out  RAM word address (the RAM is only ever read)
//   RGB          out  pixel colour {R[1:0],G[1:0],B[1:0]}
//   VGA_HSYNC    out  hsync_in delayed by 3 clocks
//   VGA_VSYNC    out  vsync_in delayed by 3 clocks
//   frame_start  out  one-clock pulse with the pixel at row 0, col 0
// -----------------------------------------------------------------------------
module fb_vga_reader #(
   parameter int unsigned LINE_WORDS = 80,
   parameter int unsigned IMG_ROWS   = 120,
   parameter logic [5:0]  BLANK_RGB  = 6'b000000
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        valid,
   input  logic [9:0]  row,
   input  logic [9:0]  col,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        test_mode,
   input  logic [15:0] spram_do,
   output logic [13:0] spram_ad,
   output logic [5:0]  RGB,
   output logic        VGA_HSYNC,
   output logic        VGA_VSYNC,
   output logic        frame_start
);

   // Last valid word of the stored image; addresses for rows below the
   // image are clamped here.
   localparam logic [13:0] AD_MAX  = 14'(IMG_ROWS * LINE_WORDS - 1);
   // Line length as a bit vector so the multiply unrolls into shift-adds.
   localparam logic [15:0] LW_BITS = 16'(LINE_WORDS);

   // Side-band bits that travel with each pixel through stages 1 and 2.
   typedef struct packed {
      logic       valid;     // pixel is in the active area
      logic       oob;       // row lies below the stored image
      logic       pix_sel;   // col[2]: 0 = pixel A, 1 = pixel B
      logic [1:0] bar;       // col[8:7]: colour-bar index
      logic       test_mode;
      logic       hsync;
      logic       vsync;
      logic       first;     // row 0, col 0 of an active frame
   } side_t;

   // Syncs idle high, everything else idles low.
   localparam side_t SIDE_RST = '{
      valid:     1'b0,
      oob:       1'b0,
      pix_sel:   1'b0,
      bar:       2'b00,
      test_mode: 1'b0,
      hsync:     1'b1,
      vsync:     1'b1,
      first:     1'b0
   };

   // ---------------------------------------------------------------------
   // Stage 1: address generation
   // ---------------------------------------------------------------------
   logic [7:0]  line;
   logic [13:0] line_base;
   logic [13:0] word_ad;
   logic        oob;
   logic [13:0] ad_d, ad_q;
   side_t       s1_d, s1_q;

   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first,
      // so no path through the block can leave it unassigned and infer a latch.
      line      = row[9:2];
      line_base = '0;
      // line * LINE_WORDS as a sum of shifted copies of line, one per set
      // bit of the constant; the unused terms fold away at elaboration.
      for (int i = 0; i < 16; i++) begin
         if (LW_BITS[i]) begin
            line_base = line_base + (14'(line) << i);
         end
      end
      word_ad = line_base + 14'(col[9:3]);
      oob     = (32'(line) >= IMG_ROWS);

      // The address only moves in the active area so the RAM address bus
      // stays quiet during blanking.
      ad_d = ad_q;
      if (valid) begin
         ad_d = oob ? AD_MAX : word_ad;
      end

      s1_d.valid     = valid;
      s1_d.oob       = oob;
      s1_d.pix_sel   = col[2];
      s1_d.bar       = col[8:7];
      s1_d.test_mode = test_mode;
      s1_d.hsync     = hsync_in;
      s1_d.vsync     = vsync_in;
      s1_d.first     = valid && (row == 10'd0) && (col == 10'd0);
   end

   // ---------------------------------------------------------------------
   // Stage 2: RAM read cycle; side-band is carried unchanged.
   // Stage 3: pixel select and output registers.
   // ---------------------------------------------------------------------
   side_t      s2_q;
   logic [5:0] rgb_d, rgb_q;
   logic       hs_q, vs_q, fs_q;

   always_comb begin
      rgb_d = BLANK_RGB;
      // Out-of-image rows blank even in test mode so the border below the
      // stored picture looks the same in both modes.
      if (s2_q.valid && !s2_q.oob) begin
         if (s2_q.test_mode) begin
            rgb_d = {3{s2_q.bar}};
         end else begin
            rgb_d = s2_q.pix_sel ? spram_do[13:8] : spram_do[5:0];
         end
      end
   end

   always_ff @(posedge clk_25MHz) begin
      // NOTE: state is updated with non-blocking assignments so every
      // stage samples the value its predecessor held before this edge.
      if (!rst_n) begin
         // Clearing every stage (not just the outputs) flushes in-flight
         // pixels, so nothing stale appears after reset is released.
         ad_q  <= '0;
         s1_q  <= SIDE_RST;
         s2_q  <= SIDE_RST;
         rgb_q <= BLANK_RGB;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else begin
         ad_q  <= ad_d;
         s1_q  <= s1_d;
         s2_q  <= s1_q;
         rgb_q <= rgb_d;
         hs_q  <= s2_q.hsync;
         vs_q  <= s2_q.vsync;
         fs_q  <= s2_q.first;
      end
   end

   assign spram_ad    = ad_q;
   assign RGB         = rgb_q;
   assign VGA_HSYNC   = hs_q;
   assign VGA_VSYNC   = vs_q;
   assign frame_start = fs_q;

   // Sub-block coordinate bits and the spare RAM data bits carry no
   // information for this block.
   logic unused_bits;
   assign unused_bits = ^{row[1:0], col[1:0], spram_do[15:14], spram_do[7:6]};

endmodule

// File: tb/tb_fb_vga_reader.sv
// -----------------------------------------------------------------------------
// tb_fb_vga_reader
//
// Bench for fb_vga_reader. A simple RAM model answers reads one clock after
// the address, returning either the address itself (echo) or a fixed word.
// A reference model derives the expected outputs from the scan coordinates
// with plain arithmetic and is compared with the DUT on every clock; directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fb_vga_reader;

   localparam int LW = 80;
   localparam int IR = 120;
   localparam logic [5:0] BLANK = 6'b000000;

   logic        clk_25MHz = 1'b0;
   logic        rst_n     = 1'b0;
   logic        valid     = 1'b0;
   logic [9:0]  row       = '0;
   logic [9:0]  col       = '0;
   logic        hsync_in  = 1'b1;
   logic        vsync_in  = 1'b1;
   logic        test_mode = 1'b0;
   logic [15:0] spram_do;
   logic [13:0] spram_ad;
   logic [5:0]  RGB;
   logic        VGA_HSYNC;
   logic        VGA_VSYNC;
   logic        frame_start;

   always #20 clk_25MHz = ~clk_25MHz;

   fb_vga_reader #(
      .LINE_WORDS(LW),
      .IMG_ROWS  (IR),
      .BLANK_RGB (BLANK)
   ) dut (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
      .valid      (valid),
      .row        (row),
      .col        (col),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .test_mode  (test_mode),
      .spram_do   (spram_do),
      .spram_ad   (spram_ad),
      .RGB        (RGB),
      .VGA_HSYNC  (VGA_HSYNC),
      .VGA_VSYNC  (VGA_VSYNC),
      .frame_start(frame_start)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- RAM model ----------------
   logic        mem_const = 1'b0;
   logic [15:0] const_do  = '0;

   always @(posedge clk_25MHz) begin
      spram_do <= mem_const ? const_do : {2'b00, spram_ad};
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit          rst;
      bit          valid;
      int          row;
      int          col;
      bit          tm;
      bit          hs;
      bit          vs;
      bit          mconst;
      logic [15:0] cdo;
   } snap_t;

   snap_t hist[4];
   int    edges  = 0;
   int    exp_ad = 0;

   function automatic int model_addr(input int r, input int c);
      if (r / 4 >= IR) return IR * LW - 1;
      return (r / 4) * LW + c / 8;
   endfunction

   // Pixel for the inputs in s, with the RAM word chosen by the mode in
   // force at the clock that performed the read.
   function automatic logic [5:0] model_pixel(input snap_t s, input bit mconst,
                                              input logic [15:0] cdo);
      int         word;
      logic [1:0] b;
      if (!s.valid || (s.row / 4 >= IR)) return BLANK;
      if (s.tm) begin
         b = 2'((s.col / 128) % 4);
         return {b, b, b};
      end
      word = mconst ? int'(cdo) : model_addr(s.row, s.col);
      if ((s.col / 4) % 2 == 1) return 6'((word >> 8) & 63);
      return 6'(word & 63);
   endfunction

   always @(posedge clk_25MHz) begin
      hist[edges % 4] = '{rst: !rst_n, valid: valid, row: int'(row), col: int'(col),
                          tm: test_mode, hs: hsync_in, vs: vsync_in,
                          mconst: mem_const, cdo: const_do};
      if (!rst_n)     exp_ad = 0;
      else if (valid) exp_ad = model_addr(int'(row), int'(col));
      edges++;
   end

   always @(negedge clk_25MHz) begin
      snap_t      cur, p1, p2;
      logic [5:0] e_rgb;
      bit         e_hs, e_vs, e_fs;
      if (edges >= 3) begin
         cur = hist[(edges - 1) % 4];
         p1  = hist[(edges - 2) % 4];
         p2  = hist[(edges - 3) % 4];
         if (cur.rst || p1.rst || p2.rst) begin
            e_rgb = BLANK; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
         end else begin
            e_rgb = model_pixel(p2, p1.mconst, p1.cdo);
            e_hs  = p2.hs;
            e_vs  = p2.vs;
            e_fs  = p2.valid && p2.row == 0 && p2.col == 0;
         end
         check("model spram_ad",    32'(spram_ad),    32'(exp_ad));
         check("model RGB",         32'(RGB),         32'(e_rgb));
         check("model VGA_HSYNC",   32'(VGA_HSYNC),   32'(e_hs));
         check("model VGA_VSYNC",   32'(VGA_VSYNC),   32'(e_vs));
         check("model frame_start", 32'(frame_start), 32'(e_fs));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic set_in(input bit v, input int r, input int c, input bit tm);
      valid     = v;
      row       = 10'(r);
      col       = 10'(c);
      test_mode = tm;
   endtask

   int first_low, lows, nonblank;
   int prev_ad, max_ad, mono_bad, hold_bad, rep_bad;
   int first_ad[480];

   initial begin
      // Reset state
      repeat (5) tick();
      check("reset RGB",         32'(RGB),         32'(BLANK));
      check("reset VGA_HSYNC",   32'(VGA_HSYNC),   32'd1);
      check("reset VGA_VSYNC",   32'(VGA_VSYNC),   32'd1);
      check("reset frame_start", 32'(frame_start), 32'd0);
      check("reset spram_ad",    32'(spram_ad),    32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

      // row 5, col 13 -> address 81, pixel B of 16'h2A15
      mem_const = 1'b1; const_do = 16'h2A15;
      set_in(1, 5, 13, 0); tick();
      check("r5c13 spram_ad", 32'(spram_ad), 32'd81);
      set_in(0, 5, 13, 0); tick(); tick();
      check("r5c13 RGB", 32'(RGB), 32'h2A);
      check("blank hold spram_ad", 32'(spram_ad), 32'd81);

      // First pixel of the frame
      const_do = 16'h1337;
      set_in(1, 0, 0, 0); tick();
      check("r0c0 spram_ad", 32'(spram_ad), 32'd0);
      set_in(0, 0, 0, 0); tick();
      check("frame_start early", 32'(frame_start), 32'd0);
      tick();
      check("frame_start pulse", 32'(frame_start), 32'd1);
      check("r0c0 RGB", 32'(RGB), 32'h37);
      tick();
      check("frame_start width", 32'(frame_start), 32'd0);

      // Colour bars
      mem_const = 1'b0;
      set_in(1, 10, 384, 1); tick();
      set_in(1, 10, 128, 1); tick();
      set_in(0, 0, 0, 0); tick();
      check("bar col384 RGB", 32'(RGB), 32'h3F);
      tick();
      check("bar col128 RGB", 32'(RGB), 32'h15);

      // Rows below the image and the last image word
      set_in(1, 500, 0, 0); tick();
      check("oob spram_ad", 32'(spram_ad), 32'd9599);
      set_in(1, 479, 639, 0); tick();
      check("last spram_ad", 32'(spram_ad), 32'd9599);
      set_in(0, 0, 0, 0); tick();
      check("oob RGB", 32'(RGB), 32'(BLANK));
      tick();
      check("last RGB", 32'(RGB), 32'h25);
      tick();

      // test_mode toggled pixel by pixel mid-line
      for (int i = 0; i < 64; i++) begin
         set_in(1, 40, i * 4, (i % 3) == 0);
         tick();
      end
      set_in(0, 0, 0, 0);
      repeat (4) tick();

      // 96-clock HSYNC pulse during blanking
      first_low = -1; lows = 0; nonblank = 0;
      for (int i = 0; i < 105; i++) begin
         hsync_in = (i < 96) ? 1'b0 : 1'b1;
         tick();
         if (!VGA_HSYNC) begin
            if (first_low < 0) first_low = i;
            lows++;
         end
         if (RGB != BLANK) nonblank++;
      end
      check("hsync delay", 32'(first_low), 32'd2);
      check("hsync width", 32'(lows), 32'd96);
      check("hsync blank RGB", 32'(nonblank), 32'd0);

      // One-clock reset in the middle of a line
      mem_const = 1'b1; const_do = 16'h0A3C;
      for (int i = 0; i < 6; i++) begin
         hsync_in = 1'b0;
         set_in(1, 8, i * 4, 0);
         if (i == 5) rst_n = 1'b0;
         tick();
      end
      check("midreset RGB",         32'(RGB),         32'(BLANK));
      check("midreset VGA_HSYNC",   32'(VGA_HSYNC),   32'd1);
      check("midreset frame_start", 32'(frame_start), 32'd0);
      rst_n = 1'b1; hsync_in = 1'b1;
      set_in(1, 8, 0, 0); tick();
      check("release+1 RGB", 32'(RGB), 32'(BLANK));
      set_in(1, 8, 4, 0); tick();
      check("release+2 RGB", 32'(RGB), 32'(BLANK));
      set_in(1, 8, 8, 0); tick();
      check("release+3 RGB", 32'(RGB), 32'h3C);
      set_in(0, 0, 0, 0); tick();
      check("release+4 RGB", 32'(RGB), 32'h0A);
      repeat (3) tick();

      // One frame, one sample per word, RAM echoing the address
      mem_const = 1'b0;
      prev_ad = 0; max_ad = 0; mono_bad = 0; hold_bad = 0; rep_bad = 0;
      for (int r = 0; r < 480; r++) begin
         vsync_in = (r >= 470 && r < 472) ? 1'b0 : 1'b1;
         for (int w = 0; w < 80; w++) begin
            set_in(1, r, w * 8 + 4 * (w % 2), 0);
            tick();
            if (w == 0) first_ad[r] = int'(spram_ad);
            else if (int'(spram_ad) < prev_ad) mono_bad++;
            if (int'(spram_ad) > max_ad) max_ad = int'(spram_ad);
            prev_ad = int'(spram_ad);
         end
         set_in(0, 0, 0, 0);
         for (int b = 0; b < 3; b++) begin
            hsync_in = (b == 0) ? 1'b0 : 1'b1;
            tick();
            if (int'(spram_ad) != prev_ad) hold_bad++;
         end
      end
      vsync_in = 1'b1;
      for (int r = 0; r < 480; r++) begin
         if (first_ad[r] != first_ad[r - (r % 4)]) rep_bad++;
         if (r % 4 == 0 && r > 0 && first_ad[r] != first_ad[r - 4] + LW) rep_bad++;
      end
      check("frame max spram_ad", 32'(max_ad), 32'd9599);
      check("frame monotonic", 32'(mono_bad), 32'd0);
      check("frame blank hold", 32'(hold_bad), 32'd0);
      check("frame line repeat", 32'(rep_bad), 32'd0);

      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
